biriscv_muldiv_issue_arb: RTL and testbench

Issue-stage arbiter and scoreboard for the shared multiplier and iterative divider in the dual-issue pipeline. Takes decoded mul/div class bits and register indices from both issue slots, grants at most one mul/div operation per cycle, and tracks in-flight destination registers. Stalls any slot with a RAW or WAW hazard against a pending result. Sits between the decoders and the mul/div execution units, and drives their issue and writeback-valid qualifiers.

---
 rtl/biriscv_muldiv_issue_arb.sv | 156 +++++++++++++++
 tb/tb_biriscv_muldiv_issue_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_muldiv_issue_arb.sv
// Issue arbiter and result scoreboard for the shared multiplier / iterative divider.
// Grants at most one mul/div per cycle (slot 0 first), stalls slots that read or
// write a register with an outstanding mul/div result, and tracks the divider as
// IDLE/BUSY/DRAIN so a flushed divide is allowed to finish but never writes back.
//
// state     | meaning
// DIV_IDLE  | divider free, may accept a new divide
// DIV_BUSY  | divide in flight, result will be written back to div_rd_q
// DIV_DRAIN | divide flushed, waiting for completion, result dropped
module biriscv_muldiv_issue_arb #(
  parameter int MUL_LATENCY = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       slot0_valid_i,
  input  logic       slot0_mul_i,
  input  logic       slot0_div_i,
  input  logic [4:0] slot0_rd_i,
  input  logic [4:0] slot0_ra_i,
  input  logic [4:0] slot0_rb_i,
  input  logic       slot1_valid_i,
  input  logic       slot1_mul_i,
  input  logic       slot1_div_i,
  input  logic [4:0] slot1_rd_i,
  input  logic [4:0] slot1_ra_i,
  input  logic [4:0] slot1_rb_i,
  input  logic       flush_i,
  input  logic       div_complete_i,
  output logic       slot0_stall_o,
  output logic       slot1_stall_o,
  output logic       mul_issue_o,
  output logic       div_issue_o,
  output logic       issue_sel_o,
  output logic       mul_wb_valid_o,
  output logic [4:0] mul_wb_rd_o,
  output logic       div_wb_valid_o,
  output logic [4:0] div_wb_rd_o,
  output logic       div_busy_o
);

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_BUSY  = 2'd1,
    DIV_DRAIN = 2'd2
  } div_state_e;

  // A single-cycle multiplier would land on top of a completing divide.
  localparam bit MulLat1 = (MUL_LATENCY == 1);

  div_state_e             div_state_q, div_state_d;
  logic [4:0]             div_rd_q, div_rd_d;
  logic [MUL_LATENCY-1:0] mul_vld_q, mul_vld_d;
  logic [4:0]             mul_rd_q [MUL_LATENCY];
  logic [4:0]             mul_rd_d [MUL_LATENCY];

  logic [31:0] pend;
  logic        req0, req1, haz0, haz1, str0, str1;
  logic [4:0]  issue_rd;

  // Destination registers with results still owed to the register file.
  always_comb begin
    pend = '0;
    if (div_state_q == DIV_BUSY) pend[div_rd_q] = 1'b1;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      if (mul_vld_q[i]) pend[mul_rd_q[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign req0 = slot0_valid_i & (slot0_mul_i | slot0_div_i);
  assign req1 = slot1_valid_i & (slot1_mul_i | slot1_div_i);
  assign haz0 = slot0_valid_i & (pend[slot0_ra_i] | pend[slot0_rb_i] | pend[slot0_rd_i]);
  assign haz1 = slot1_valid_i & (pend[slot1_ra_i] | pend[slot1_rb_i] | pend[slot1_rd_i]);
  assign str0 = slot0_valid_i & ((slot0_div_i & (div_state_q != DIV_IDLE)) |
                                 (slot0_mul_i & MulLat1 & (div_state_q == DIV_BUSY)));
  assign str1 = slot1_valid_i & ((slot1_div_i & (div_state_q != DIV_IDLE)) |
                                 (slot1_mul_i & MulLat1 & (div_state_q == DIV_BUSY)));

  assign slot0_stall_o = haz0 | str0;
  assign slot1_stall_o = slot0_stall_o | haz1 | str1 | (req0 & req1);
  assign issue_sel_o   = ~req0;
  assign issue_rd      = issue_sel_o ? slot1_rd_i : slot0_rd_i;

  // Grant the selected slot to whichever unit its class names.
  always_comb begin
    mul_issue_o = 1'b0;
    div_issue_o = 1'b0;
    if (!flush_i) begin
      if (req0) begin
        mul_issue_o = slot0_mul_i & ~slot0_stall_o;
        div_issue_o = slot0_div_i & ~slot0_stall_o;
      end else begin
        mul_issue_o = slot1_valid_i & slot1_mul_i & ~slot1_stall_o;
        div_issue_o = slot1_valid_i & slot1_div_i & ~slot1_stall_o;
      end
    end
  end

  // Multiplier tracker shift; a flush kills younger stages but lets the op about to land finish.
  always_comb begin
    mul_vld_d[0] = mul_issue_o;
    mul_rd_d[0]  = mul_issue_o ? issue_rd : 5'd0;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      mul_vld_d[i] = mul_vld_q[i-1] & (~flush_i | (i == MUL_LATENCY - 1));
      mul_rd_d[i]  = mul_rd_q[i-1];
    end
  end

  // Divider FSM next state.
  always_comb begin
    div_state_d = div_state_q;
    div_rd_d    = div_rd_q;
    case (div_state_q)
      DIV_IDLE: begin
        if (div_issue_o) begin
          div_state_d = DIV_BUSY;
          div_rd_d    = issue_rd;
        end
      end
      DIV_BUSY: begin
        if (div_complete_i)  div_state_d = DIV_IDLE;
        else if (flush_i)    div_state_d = DIV_DRAIN;
      end
      DIV_DRAIN: begin
        if (div_complete_i)  div_state_d = DIV_IDLE;
      end
      default: div_state_d = DIV_IDLE;
    endcase
  end

  assign mul_wb_valid_o = mul_vld_q[MUL_LATENCY-1];
  assign mul_wb_rd_o    = mul_rd_q[MUL_LATENCY-1];
  assign div_wb_valid_o = div_complete_i & (div_state_q == DIV_BUSY);
  assign div_wb_rd_o    = div_rd_q;
  assign div_busy_o     = (div_state_q != DIV_IDLE);

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_state_q <= DIV_IDLE;
      div_rd_q    <= '0;
      mul_vld_q   <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) mul_rd_q[i] <= '0;
    end else begin
      div_state_q <= div_state_d;
      div_rd_q    <= div_rd_d;
      mul_vld_q   <= mul_vld_d;
      for (int i = 0; i < MUL_LATENCY; i++) mul_rd_q[i] <= mul_rd_d[i];
    end
  end

  one_class_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(slot0_valid_i && slot0_mul_i && slot0_div_i) &&
    !(slot1_valid_i && slot1_mul_i && slot1_div_i));

endmodule

// File: tb/tb_biriscv_muldiv_issue_arb.sv
// Bench for biriscv_muldiv_issue_arb: directed scenarios followed by random traffic,
// checked against a queue-based model of in-flight results and a writeback scoreboard.
module tb_biriscv_muldiv_issue_arb;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic v0, m0, d0, v1, m1, d1, flush, dc;
  logic [4:0] rd0, ra0, rb0, rd1, ra1, rb1;
  logic s0_stall, s1_stall, mul_iss, div_iss, sel, mul_wbv, div_wbv, div_busy;
  logic [4:0] mul_wbrd, div_wbrd;

  biriscv_muldiv_issue_arb #(.MUL_LATENCY(L)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slot0_valid_i(v0), .slot0_mul_i(m0), .slot0_div_i(d0),
    .slot0_rd_i(rd0), .slot0_ra_i(ra0), .slot0_rb_i(rb0),
    .slot1_valid_i(v1), .slot1_mul_i(m1), .slot1_div_i(d1),
    .slot1_rd_i(rd1), .slot1_ra_i(ra1), .slot1_rb_i(rb1),
    .flush_i(flush), .div_complete_i(dc),
    .slot0_stall_o(s0_stall), .slot1_stall_o(s1_stall),
    .mul_issue_o(mul_iss), .div_issue_o(div_iss), .issue_sel_o(sel),
    .mul_wb_valid_o(mul_wbv), .mul_wb_rd_o(mul_wbrd),
    .div_wb_valid_o(div_wbv), .div_wb_rd_o(div_wbrd),
    .div_busy_o(div_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic r; logic fl; logic dc;
    logic v0; logic m0; logic d0; logic [4:0] rd0; logic [4:0] ra0; logic [4:0] rb0;
    logic v1; logic m1; logic d1; logic [4:0] rd1; logic [4:0] ra1; logic [4:0] rb1;
  } stim_t;

  typedef struct { logic [4:0] rd; int due; } wb_t;

  wb_t mfly[$];   // model: multiplies in flight (rd, writeback cycle)
  wb_t msb[$];    // scoreboard: expected multiplier writebacks
  wb_t dsb[$];    // scoreboard: expected divider writebacks
  bit  busy, drain, just_rst;
  logic [4:0] drd;

  int checks = 0;
  int passed = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  function automatic bit pend(logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (busy && drd == r) return 1'b1;
    foreach (mfly[i]) if (mfly[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.r = 1'b1;
    return s;
  endfunction

  function automatic stim_t mk(bit a_v0, bit a_m0, bit a_d0, logic [4:0] a_rd0, logic [4:0] a_ra0,
                               logic [4:0] a_rb0, bit a_v1, bit a_m1, bit a_d1, logic [4:0] a_rd1,
                               logic [4:0] a_ra1, logic [4:0] a_rb1, bit a_fl, bit a_dc);
    stim_t s;
    s = idle();
    s.v0 = a_v0; s.m0 = a_m0; s.d0 = a_d0; s.rd0 = a_rd0; s.ra0 = a_ra0; s.rb0 = a_rb0;
    s.v1 = a_v1; s.m1 = a_m1; s.d1 = a_d1; s.rd1 = a_rd1; s.ra1 = a_ra1; s.rb1 = a_rb1;
    s.fl = a_fl; s.dc = a_dc;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    int k;
    s = idle();
    if ($urandom_range(0, 199) == 0) begin
      s = '0;
      return s;
    end
    s.v0 = ($urandom_range(0, 3) != 0);
    k = $urandom_range(0, 3);
    s.m0 = (k == 0); s.d0 = (k == 1);
    s.v1 = ($urandom_range(0, 3) != 0);
    k = $urandom_range(0, 3);
    s.m1 = (k == 0); s.d1 = (k == 1);
    s.rd0 = 5'($urandom_range(0, 7)); s.ra0 = 5'($urandom_range(0, 7)); s.rb0 = 5'($urandom_range(0, 7));
    s.rd1 = 5'($urandom_range(0, 7)); s.ra1 = 5'($urandom_range(0, 7)); s.rb1 = 5'($urandom_range(0, 7));
    s.fl = ($urandom_range(0, 11) == 0);
    s.dc = ($urandom_range(0, 5) == 0);
    return s;
  endfunction

  // Drive one cycle, check the combinational decision, then advance the model.
  task automatic step(input stim_t s);
    logic req0, req1, h0, h1, st0, st1, e_s0, e_s1, e_mi, e_di;
    logic [4:0] ird;
    @(negedge clk);
    rst_n = s.r; flush = s.fl; dc = s.dc;
    v0 = s.v0; m0 = s.m0; d0 = s.d0; rd0 = s.rd0; ra0 = s.ra0; rb0 = s.rb0;
    v1 = s.v1; m1 = s.m1; d1 = s.d1; rd1 = s.rd1; ra1 = s.ra1; rb1 = s.rb1;
    #1;
    while (mfly.size() > 0 && mfly[0].due < cyc) void'(mfly.pop_front());
    req0 = s.v0 && (s.m0 || s.d0);
    req1 = s.v1 && (s.m1 || s.d1);
    h0 = s.v0 && (pend(s.ra0) || pend(s.rb0) || pend(s.rd0));
    h1 = s.v1 && (pend(s.ra1) || pend(s.rb1) || pend(s.rd1));
    st0 = s.v0 && ((s.d0 && (busy || drain)) || (s.m0 && L == 1 && busy));
    st1 = s.v1 && ((s.d1 && (busy || drain)) || (s.m1 && L == 1 && busy));
    e_s0 = h0 || st0;
    e_s1 = e_s0 || h1 || st1 || (req0 && req1);
    if (req0) begin
      e_mi = s.m0 && !e_s0; e_di = s.d0 && !e_s0; ird = s.rd0;
    end else begin
      e_mi = s.v1 && s.m1 && !e_s1; e_di = s.v1 && s.d1 && !e_s1; ird = s.rd1;
    end
    if (s.fl) begin
      e_mi = 1'b0; e_di = 1'b0;
    end
    chk("slot0_stall", s0_stall, e_s0);
    chk("slot1_stall", s1_stall, e_s1);
    chk("mul_issue", mul_iss, e_mi);
    chk("div_issue", div_iss, e_di);
    chk("issue_sel", sel, !req0);
    chk("div_busy", div_busy, busy || drain);
    if (just_rst) begin
      chk("mul_wb_rd_reset", mul_wbrd, 0);
      chk("div_wb_rd_reset", div_wbrd, 0);
      just_rst = 1'b0;
    end
    if (busy && s.dc) dsb.push_back('{rd: drd, due: cyc});
    if (!s.r) begin
      while (mfly.size() > 0 && mfly[$].due > cyc) void'(mfly.pop_back());
      while (msb.size() > 0 && msb[$].due > cyc) void'(msb.pop_back());
      busy = 1'b0; drain = 1'b0; drd = 5'd0; just_rst = 1'b1;
    end else begin
      if (e_mi) begin
        mfly.push_back('{rd: ird, due: cyc + L});
        msb.push_back('{rd: ird, due: cyc + L});
      end
      if (s.fl) begin
        while (mfly.size() > 0 && mfly[$].due > cyc + 1) void'(mfly.pop_back());
        while (msb.size() > 0 && msb[$].due > cyc + 1) void'(msb.pop_back());
      end
      if (busy) begin
        if (s.dc) busy = 1'b0;
        else if (s.fl) begin busy = 1'b0; drain = 1'b1; end
      end else if (drain) begin
        if (s.dc) drain = 1'b0;
      end else if (e_di) begin
        busy = 1'b1; drd = ird;
      end
    end
  endtask

  // Multiplier writeback monitor.
  always @(negedge clk) begin
    wb_t w;
    #2;
    if (mul_wbv === 1'b1) begin
      if (msb.size() == 0) chk("mul_wb_valid", mul_wbv, 0);
      else begin
        w = msb.pop_front();
        chk("mul_wb_rd", mul_wbrd, w.rd);
        chk("mul_wb_cycle", cyc, w.due);
      end
    end else if (msb.size() > 0 && msb[0].due <= cyc) begin
      chk("mul_wb_valid", mul_wbv, 1);
      void'(msb.pop_front());
    end
  end

  // Divider writeback monitor.
  always @(negedge clk) begin
    wb_t w;
    #2;
    if (div_wbv === 1'b1) begin
      if (dsb.size() == 0) chk("div_wb_valid", div_wbv, 0);
      else begin
        w = dsb.pop_front();
        chk("div_wb_rd", div_wbrd, w.rd);
        chk("div_wb_cycle", cyc, w.due);
      end
    end else if (dsb.size() > 0 && dsb[0].due <= cyc) begin
      chk("div_wb_valid", div_wbv, 1);
      void'(dsb.pop_front());
    end
  end

  initial begin
    {v0, m0, d0, v1, m1, d1, flush, dc} = '0;
    {rd0, ra0, rb0, rd1, ra1, rb1} = '0;
    rst_n = 1'b0;
    busy = 1'b0; drain = 1'b0; drd = 5'd0; just_rst = 1'b1;
    repeat (3) @(negedge clk);

    // single multiply
    step(mk(1,1,0,5,1,2, 0,0,0,0,0,0, 0,0));
    repeat (3) step(idle());

    // RAW on a divide result, completion ten cycles after issue
    step(mk(1,0,1,7,1,2, 0,0,0,0,0,0, 0,0));
    repeat (9) step(mk(1,0,0,8,7,3, 0,0,0,0,0,0, 0,0));
    step(mk(1,0,0,8,7,3, 0,0,0,0,0,0, 0,1));
    step(mk(1,0,0,8,7,3, 0,0,0,0,0,0, 0,0));
    step(idle());

    // dual contention: mul in slot0, div in slot1
    step(mk(1,1,0,3,1,2, 1,0,1,4,5,6, 0,0));
    step(mk(0,0,0,0,0,0, 1,0,1,4,5,6, 0,0));
    repeat (4) step(idle());
    step(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 0,1));
    step(idle());

    // flush during a divide, new divide waits for the drain
    step(mk(1,0,1,9,1,2, 0,0,0,0,0,0, 0,0));
    repeat (2) step(idle());
    step(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 1,0));
    repeat (4) step(mk(1,0,1,11,1,2, 0,0,0,0,0,0, 0,0));
    step(mk(1,0,1,11,1,2, 0,0,0,0,0,0, 0,1));
    step(mk(1,0,1,11,1,2, 0,0,0,0,0,0, 0,0));
    repeat (3) step(idle());
    step(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 0,1));
    step(idle());

    // x0 never hazards; slot0 hazard holds an independent slot1
    step(mk(1,1,0,0,1,2, 0,0,0,0,0,0, 0,0));
    step(mk(1,0,0,1,0,0, 1,0,0,2,3,4, 0,0));
    step(mk(1,1,0,6,1,2, 0,0,0,0,0,0, 0,0));
    step(mk(1,0,0,1,6,2, 1,0,0,2,3,4, 0,0));
    repeat (3) step(idle());

    // reset in the middle of a divide, then a stray completion
    step(mk(1,0,1,10,1,2, 0,0,0,0,0,0, 0,0));
    repeat (2) step(idle());
    step('0);
    step(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 0,1));
    step(idle());

    repeat (3000) step(rnd());
    repeat (4) step(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 0,1));
    repeat (4) step(idle());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
